// File: rtl/fifo_reader.sv
//------------------------------------------------------------------------------
// Module   : fifo_reader
// Brief    : Drains an upstream FIFO into a 2-entry output buffer with a
//            valid/ready interface. Bursting starts once the FIFO rises above
//            its almost-empty threshold. Optional idle timeout drain is
//            enabled by defining FIFO_READER_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fifo_reader #(
    parameter int WORD_SIZE = 12,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 almost_empty,
    input  logic [WORD_SIZE-1:0] fifo_data_out,
    output logic                 fifo_rd,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [WORD_SIZE-1:0] data_out,
    output logic [15:0]          word_count,
    output logic                 busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_occ;
    logic                   r_rd_q;
    logic [WORD_SIZE-1:0]   r_buf0;
    logic [WORD_SIZE-1:0]   r_buf1;
    logic [15:0]            r_word_count;

    logic                   w_pop;
    logic [1:0]             w_occ_after_pop;
    logic [2:0]             w_level;
    logic                   w_wr_slot0;
    logic                   w_start;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range_check
            $error("fifo_reader: TIMEOUT must be in 1..15");
        end
    endgenerate

    assign valid_out       = (r_occ != 2'd0);
    assign data_out        = r_buf0;
    assign busy            = (r_state == S_BURST);
    assign word_count      = r_word_count;
    assign w_pop           = valid_out & ready_in;
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    assign w_wr_slot0      = (w_occ_after_pop == 2'd0);

    // Occupancy once this edge's pop and in-flight word have settled; a new
    // read is only safe if that leaves room for the word it will return.
    assign w_level = {1'b0, w_occ_after_pop} + {2'b00, r_rd_q};
    assign fifo_rd = (r_state == S_BURST) & ~fifo_empty & (w_level <= 3'd1);

`ifdef FIFO_READER_TIMEOUT_EN
    localparam logic [3:0] c_TIMEOUT_LAST = 4'(TIMEOUT - 1);

    logic [3:0] r_tmo_cnt;
    logic       w_tmo_count;
    logic       w_tmo_hit;

    assign w_tmo_count = (r_state == S_IDLE) & ~fifo_empty & almost_empty;
    assign w_tmo_hit   = w_tmo_count & (r_tmo_cnt == c_TIMEOUT_LAST);
    assign w_start     = (~fifo_empty & ~almost_empty) | w_tmo_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= 4'd0;
        end else if (w_tmo_count && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 4'd1;
        end else begin
            r_tmo_cnt <= 4'd0;
        end
    end
`else
    assign w_start = ~fifo_empty & ~almost_empty;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (fifo_empty && !fifo_rd) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In-flight word lands behind whatever survives this edge's pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_q       <= 1'b0;
            r_occ        <= 2'd0;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_word_count <= 16'd0;
        end else begin
            r_rd_q <= fifo_rd;
            r_occ  <= w_occ_after_pop + {1'b0, r_rd_q};
            if (w_pop) begin
                r_buf0       <= r_buf1;
                r_word_count <= r_word_count + 16'd1;
            end
            if (r_rd_q) begin
                if (w_wr_slot0) begin
                    r_buf0 <= fifo_data_out;
                end else begin
                    r_buf1 <= fifo_data_out;
                end
            end
        end
    end

endmodule

`default_nettype wire
